// File: rtl/trail_particle_pool.sv
// -----------------------------------------------------------------------------
// trail_particle_pool
//   Particle pool for the player's exhaust trail. Every SPAWN_PERIOD run ticks
//   a burst of BURST particles is written behind the player into the next
//   group of slots (round robin). On every run or crash tick each live
//   particle scrolls left and loses one unit of life. In run mode it also
//   drifts vertically with the player's velocity. All state advances only on
//   frame_tick. The pool is exposed to the renderer as packed per-slot buses.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   frame_tick     one-cycle strobe per video frame; inputs sampled only then
//   mode           00 clear, 01 run, 10 pause, 11 crash
//   player_y       player top edge (spawn origin)
//   velocity       player speed magnitude; vel_dir 0 = up, 1 = down
//   at_boundary    player touching upper/lower bound (suppresses drift)
//   part_x/y/life  packed per-slot state, slot 0 in the LSBs; life 0 = dead
//   active_count   registered popcount of live slots (one clk behind state)
//   drop_count     saturating count of live particles overwritten by bursts
//
// When N_PART is not a multiple of BURST, the trailing N_PART % BURST slots
// belong to no group; they are never spawned and stay dead.
// -----------------------------------------------------------------------------
module trail_particle_pool #(
    parameter int N_PART       = 48,
    parameter int BURST        = 5,
    parameter int X_W          = 10,
    parameter int Y_W          = 9,
    parameter int LIFE_W       = 4,
    parameter int SPAWN_PERIOD = 3,
    parameter int SPAWN_X      = 152,
    parameter int H_SPEED      = 4,
    parameter int X_MIN        = 10,
    parameter int PLAYER_SIZE  = 40,
    parameter int Y_OFS        = 4,
    parameter int LIFE_CENTER  = 10,
    parameter int LIFE_STEP    = 2,
    parameter int DRIFT_SHIFT  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_tick,
    input  logic [1:0]                   mode,
    input  logic [Y_W-1:0]               player_y,
    input  logic [8:0]                   velocity,
    input  logic                         vel_dir,
    input  logic                         at_boundary,
    output logic [N_PART*X_W-1:0]        part_x,
    output logic [N_PART*Y_W-1:0]        part_y,
    output logic [N_PART*LIFE_W-1:0]     part_life,
    output logic [$clog2(N_PART+1)-1:0]  active_count,
    output logic [7:0]                   drop_count
);

    localparam int N_GROUPS = N_PART / BURST;
    localparam int PTR_W    = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
    localparam int TMR_W    = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam int ACT_W    = $clog2(N_PART + 1);
    localparam int DADD_W   = $clog2(BURST + 1);
    localparam int SW       = ((Y_W > 9) ? Y_W : 9) + 1;   // headroom for y +/- drift
    localparam int Y_MAX    = (1 << Y_W) - 1;
    localparam int Y_STEP   = PLAYER_SIZE / (BURST - 1);

    // Tick qualifiers
    logic tick_clear, tick_run, tick_age, spawn_fire, drift_en;
    logic [PTR_W-1:0]  grp_ptr_reg;
    logic [TMR_W-1:0]  timer_reg;
    logic [ACT_W-1:0]  active_count_reg, live_cnt;
    logic [7:0]        drop_count_reg;
    logic [DADD_W-1:0] drop_add;
    logic [8:0]        drop_sum;
    logic [8:0]        drift_amt;
    logic [N_PART-1:0] live_vec;

    assign tick_clear = frame_tick && (mode == 2'b00);
    assign tick_run   = frame_tick && (mode == 2'b01);
    assign tick_age   = frame_tick && mode[0];          // run (01) or crash (11)
    assign spawn_fire = tick_run && (timer_reg == TMR_W'(SPAWN_PERIOD - 1));
    assign drift_en   = tick_run && (velocity > 9'd1) && !at_boundary;
    assign drift_amt  = velocity >> DRIFT_SHIFT;

    // ------------------------------------------------------------------
    // Per-slot state
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_PART; gi++) begin : g_slot
            localparam int J        = gi % BURST;
            localparam int G        = gi / BURST;
            localparam int DIST     = (J > BURST / 2) ? (J - BURST / 2) : (BURST / 2 - J);
            localparam int LIFE_RAW = LIFE_CENTER - DIST * LIFE_STEP;
            localparam int LIFE_SP  = (LIFE_RAW < 1) ? 1 : LIFE_RAW;
            localparam int DY       = J * Y_STEP + Y_OFS;

            logic [X_W-1:0]    x_reg;
            logic [Y_W-1:0]    y_reg, y_drift;
            logic [LIFE_W-1:0] life_reg;
            logic [SW-1:0]     y_up;
            logic              hit;

            if (G < N_GROUPS) begin : g_hit
                assign hit = spawn_fire && (grp_ptr_reg == PTR_W'(G));
            end else begin : g_nohit
                assign hit = 1'b0;
            end

            // Saturating drift: clamp to the top of the y range going up,
            // to 0 going down.
            assign y_up = SW'(y_reg) + SW'(drift_amt);
            always_comb begin
                y_drift = y_reg;
                if (vel_dir) begin
                    y_drift = (SW'(drift_amt) > SW'(y_reg)) ? '0 : (y_reg - Y_W'(drift_amt));
                end else begin
                    y_drift = (y_up > SW'(Y_MAX)) ? Y_W'(Y_MAX) : y_up[Y_W-1:0];
                end
            end

            always_ff @(posedge clk) begin
                if (rst || tick_clear) begin
                    x_reg    <= '0;
                    y_reg    <= '0;
                    life_reg <= '0;
                end else if (tick_age) begin
                    if (hit) begin
                        // Spawn wins over age/drift for the written group.
                        x_reg    <= X_W'(SPAWN_X);
                        y_reg    <= player_y + Y_W'(DY);
                        life_reg <= LIFE_W'(LIFE_SP);
                    end else if (life_reg != '0) begin
                        x_reg <= x_reg - X_W'(H_SPEED);
                        // Kill test uses the pre-scroll x.
                        if ((x_reg < X_W'(X_MIN)) || (life_reg == LIFE_W'(1)))
                            life_reg <= '0;
                        else
                            life_reg <= life_reg - LIFE_W'(1);
                        if (drift_en)
                            y_reg <= y_drift;
                    end
                end
            end

            assign live_vec[gi]                       = (life_reg != '0);
            assign part_x[gi*X_W +: X_W]              = x_reg;
            assign part_y[gi*Y_W +: Y_W]              = y_reg;
            assign part_life[gi*LIFE_W +: LIFE_W]     = life_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Counters: live slots in the group about to be overwritten, and pool
    // popcount
    // ------------------------------------------------------------------
    always_comb begin
        drop_add = '0;
        for (int g = 0; g < N_GROUPS; g++) begin
            if (grp_ptr_reg == PTR_W'(g)) begin
                for (int j = 0; j < BURST; j++)
                    drop_add = drop_add + DADD_W'(live_vec[g*BURST + j]);
            end
        end
    end

    always_comb begin
        live_cnt = '0;
        for (int i = 0; i < N_PART; i++)
            live_cnt = live_cnt + ACT_W'(live_vec[i]);
    end

    assign drop_sum = {1'b0, drop_count_reg} + 9'(drop_add);

    // ------------------------------------------------------------------
    // Spawn timer, group pointer, drop counter, active count
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || tick_clear) begin
            timer_reg      <= '0;
            grp_ptr_reg    <= '0;
            drop_count_reg <= '0;
        end else if (tick_run) begin
            if (spawn_fire) begin
                timer_reg      <= '0;
                grp_ptr_reg    <= (grp_ptr_reg == PTR_W'(N_GROUPS - 1)) ? '0 : grp_ptr_reg + PTR_W'(1);
                drop_count_reg <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            end else begin
                timer_reg <= timer_reg + TMR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            active_count_reg <= '0;
        else
            active_count_reg <= live_cnt;
    end

    assign active_count = active_count_reg;
    assign drop_count   = drop_count_reg;

endmodule
